// File: rtl/mux_reduce_pipe.sv
// rtl/mux_reduce_pipe.sv - pipelined OR/AND/XOR/NOR reduction tree built from 2:1 mux cells
// One tree level per register stage; mode travels with its data through the valid/ready pipe.
module mux_reduce_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int P      = 1 << LEVELS;

  function automatic logic mux2(input logic sel, input logic d0, input logic d1);
    return sel ? d1 : d0;
  endfunction

  function automatic logic not_cell(input logic a);
    return mux2(a, 1'b1, 1'b0);
  endfunction

  // Mode 11 (NOR) reuses the OR cell; its inversion happens after the last register.
  function automatic logic reduce_cell(input logic a, input logic b, input logic [1:0] mode);
    logic or_y, and_y, xor_y, lo_y, hi_y;
    or_y  = mux2(a, b, 1'b1);
    and_y = mux2(a, 1'b0, b);
    xor_y = mux2(a, b, not_cell(b));
    lo_y  = mux2(mode[0], or_y, and_y);
    hi_y  = mux2(mode[0], xor_y, or_y);
    return mux2(mode[1], lo_y, hi_y);
  endfunction

  function automatic logic final_cell(input logic x, input logic [1:0] mode);
    logic is_nor;
    is_nor = mux2(mode[1], 1'b0, mode[0]);
    return mux2(is_nor, x, not_cell(x));
  endfunction

  logic [P-1:0]      padded;
  logic [P-2:0]      tree_q;
  logic [P-2:0]      tree_d;
  logic [P-2:0]      ld;
  logic [LEVELS-1:0] valid_q;
  logic [LEVELS-1:0] valid_src;
  logic [1:0]        mode_q   [LEVELS];
  logic [1:0]        mode_src [LEVELS];
  logic [LEVELS:0]   rdy;

  // Lanes beyond WIDTH carry the identity of the incoming mode: 1 for AND, else 0.
  for (genvar i = 0; i < P; i++) begin : g_pad
    if (i < WIDTH) begin : g_data
      assign padded[i] = in_data[i];
    end else begin : g_ident
      assign padded[i] = mux2(in_mode[1], in_mode[0], 1'b0);
    end
  end

  assign rdy[LEVELS] = out_ready;

  // Stage k occupies tree_q[P-(P>>k) +: P>>(k+1)] and reads the previous stage's slice.
  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int N       = P >> (k + 1);
    localparam int OUT_OFF = P - (P >> k);
    localparam int SRC_OFF = P - 2 * (P >> k);

    if (k == 0) begin : g_first
      assign valid_src[k] = in_valid;
      assign mode_src[k]  = in_mode;
      for (genvar j = 0; j < N; j++) begin : g_cell
        if (LEVELS == 1) begin : g_last
          assign tree_d[OUT_OFF+j] = reduce_cell(padded[2*j], padded[2*j+1], mode_src[k]);
        end else begin : g_mid
          assign tree_d[OUT_OFF+j] = reduce_cell(padded[2*j], padded[2*j+1], mode_src[k]);
        end
      end
    end else begin : g_next
      assign valid_src[k] = valid_q[k-1];
      assign mode_src[k]  = mode_q[k-1];
      for (genvar j = 0; j < N; j++) begin : g_cell
        assign tree_d[OUT_OFF+j] =
          reduce_cell(tree_q[SRC_OFF+2*j], tree_q[SRC_OFF+2*j+1], mode_src[k]);
      end
    end

    assign ld[OUT_OFF +: N] = {N{rdy[k]}};
    assign rdy[k]           = ~valid_q[k] | rdy[k+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tree_q  <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        mode_q[k] <= 2'b00;
      end
    end else begin
      for (int k = 0; k < LEVELS; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= valid_src[k];
          mode_q[k]  <= mode_src[k];
        end
      end
      for (int b = 0; b < P - 1; b++) begin
        if (ld[b]) begin
          tree_q[b] <= tree_d[b];
        end
      end
    end
  end

  assign in_ready  = rdy[0] & rst_n;
  assign out_valid = valid_q[LEVELS-1];
  assign out_data  = final_cell(tree_q[P-2], mode_q[LEVELS-1]);

endmodule

// File: tb/tb_mux_reduce_pipe.sv
// tb/tb_mux_reduce_pipe.sv - scoreboard bench for mux_reduce_pipe across several widths
module tb_mux_reduce_pipe;

  localparam int NI       = 6;
  localparam int WS [NI]  = '{2, 3, 5, 8, 13, 64};
  localparam int LV [NI]  = '{1, 2, 3, 3, 4, 6};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] iv, ir, ov, ordy, od;
  logic [63:0]   idata [NI];
  logic [1:0]    imode [NI];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit chk_lat    = 1'b0;

  bit exp_mem [NI][256];
  int acc_cyc [NI][256];
  bit obs     [NI][256];
  int wr_ptr  [NI];
  int rd_ptr  [NI];
  int nobs    [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    mux_reduce_pipe #(.WIDTH(WS[gi])) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv[gi]),
      .in_ready (ir[gi]),
      .in_data  (idata[gi][WS[gi]-1:0]),
      .in_mode  (imode[gi]),
      .out_valid(ov[gi]),
      .out_ready(ordy[gi]),
      .out_data (od[gi])
    );
  end

  // Reference: count the ones among the low w bits and decide from the count.
  function automatic bit ref_reduce(input logic [63:0] d, input logic [1:0] m, input int w);
    int ones;
    ones = 0;
    for (int b = 0; b < w; b++) ones += int'(d[b]);
    case (m)
      2'd0:    return ones != 0;
      2'd1:    return ones == w;
      2'd2:    return (ones % 2) == 1;
      default: return ones == 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: retire before capture so an empty scoreboard never matches a same-cycle push.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        rd_ptr[i] = wr_ptr[i];
      end else begin
        if (ov[i] && ordy[i]) begin
          compared++;
          if (rd_ptr[i] == wr_ptr[i]) begin
            mismatched++;
            $display("FAIL out_unexpected W=%0d: out_valid=1 with nothing outstanding", WS[i]);
          end else begin
            if (od[i] !== exp_mem[i][rd_ptr[i] % 256]) begin
              mismatched++;
              $display("FAIL out_data W=%0d: got %0b expected %0b", WS[i], od[i],
                       exp_mem[i][rd_ptr[i] % 256]);
            end
            if (chk_lat) begin
              compared++;
              if (cyc - acc_cyc[i][rd_ptr[i] % 256] != LV[i]) begin
                mismatched++;
                $display("FAIL latency W=%0d: got %0d expected %0d", WS[i],
                         cyc - acc_cyc[i][rd_ptr[i] % 256], LV[i]);
              end
            end
            obs[i][nobs[i] % 256] = od[i];
            nobs[i]++;
            rd_ptr[i]++;
          end
        end
        if (iv[i] && ir[i]) begin
          exp_mem[i][wr_ptr[i] % 256] = ref_reduce(idata[i], imode[i], WS[i]);
          acc_cyc[i][wr_ptr[i] % 256] = cyc;
          wr_ptr[i]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [63:0] d, input logic [1:0] m);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    iv[i]    = 1'b1;
    idata[i] = d;
    imode[i] = m;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ir[i];
      step();
      n++;
    end
    chk("send_accept", acc, 1);
    iv[i] = 1'b0;
  endtask

  task automatic wait_obs(input int i, input int target);
    int n;
    n = 0;
    while (nobs[i] < target && n < 40) begin
      step();
      n++;
    end
    chk("result_arrival", nobs[i] >= target, 1);
  endtask

  logic [63:0] fd [4];
  logic [1:0]  fm [4];
  int          base;

  initial begin
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '1;
    for (int i = 0; i < NI; i++) begin
      idata[i] = '0;
      imode[i] = 2'b00;
    end
    #2;
    chk("reset_out_valid", ov, 0);
    chk("reset_out_data", od, 0);
    chk("reset_in_ready", ir, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", ir, {NI{1'b1}});
    step();

    // Zero vector in all four modes, back-to-back, latency checked by the monitor.
    chk_lat = 1'b1;
    base = nobs[3];
    for (int m = 0; m < 4; m++) send(3, 64'h0, 2'(m));
    wait_obs(3, base + 4);
    chk("zero_or",  obs[3][(base + 0) % 256], 0);
    chk("zero_and", obs[3][(base + 1) % 256], 0);
    chk("zero_xor", obs[3][(base + 2) % 256], 0);
    chk("zero_nor", obs[3][(base + 3) % 256], 1);

    base = nobs[3];
    send(3, 64'hFF, 2'd2);
    send(3, 64'h01, 2'd2);
    send(3, 64'h81, 2'd2);
    wait_obs(3, base + 3);
    chk("xor_ff", obs[3][(base + 0) % 256], 0);
    chk("xor_01", obs[3][(base + 1) % 256], 1);
    chk("xor_81", obs[3][(base + 2) % 256], 0);

    base = nobs[2];
    send(2, 64'h1F, 2'd1);
    send(2, 64'h00, 2'd0);
    wait_obs(2, base + 2);
    chk("w5_and_pad", obs[2][(base + 0) % 256], 1);
    chk("w5_or_pad",  obs[2][(base + 1) % 256], 0);
    chk_lat = 1'b0;

    // Fill the W=8 pipe under backpressure, then release for exactly one cycle.
    ordy[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fd[k] = {$urandom, $urandom};
      fm[k] = 2'($urandom_range(0, 3));
    end
    for (int k = 0; k < 5; k++) begin
      iv[3]    = 1'b1;
      idata[3] = fd[(k < 3) ? k : 3];
      imode[3] = fm[(k < 3) ? k : 3];
      #1;
      chk("fill_in_ready", ir[3], (k < 3) ? 1 : 0);
      step();
    end
    chk("stall_out_valid", ov[3], 1);
    chk("stall_out_data", od[3], ref_reduce(fd[0], fm[0], 8));
    step();
    chk("stall_hold_valid", ov[3], 1);
    chk("stall_hold_data", od[3], ref_reduce(fd[0], fm[0], 8));
    ordy[3] = 1'b1;
    #1;
    chk("release_in_ready", ir[3], 1);
    base = nobs[3];
    step();
    ordy[3] = 1'b0;
    iv[3]   = 1'b0;
    #1;
    chk("one_retired", nobs[3], base + 1);
    chk("refull_in_ready", ir[3], 0);
    chk("next_out_data", od[3], ref_reduce(fd[1], fm[1], 8));
    ordy[3] = 1'b1;
    wait_obs(3, base + 4);
    chk("late_accept_order", obs[3][(base + 3) % 256], ref_reduce(fd[3], fm[3], 8));

    // Reset with two transactions in flight, the older one presented at the output.
    send(3, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    send(3, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    ordy[3] = 1'b0;
    step();
    chk("pre_reset_out_valid", ov[3], 1);
    rst_n = 1'b0;
    #1;
    chk("inflight_reset_valid", ov, 0);
    chk("inflight_reset_data", od, 0);
    chk("inflight_reset_ready", ir, 0);
    step();
    rst_n   = 1'b1;
    ordy[3] = 1'b1;
    #1;
    chk("post_reset_in_ready", ir[3], 1);
    base = nobs[3];
    repeat (6) step();
    chk("no_stale_output", nobs[3], base);
    chk("no_stale_valid", ov[3], 0);

    // Random traffic on every width with independent valid/ready toggling.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        iv[i]    = ($urandom_range(0, 3) != 0);
        idata[i] = {$urandom, $urandom};
        imode[i] = 2'($urandom_range(0, 3));
        ordy[i]  = ($urandom_range(0, 2) != 0);
      end
      step();
    end
    iv   = '0;
    ordy = '1;
    repeat (20) step();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("drain_empty_w%0d", WS[i]), wr_ptr[i] - rd_ptr[i], 0);
      chk($sformatf("traffic_seen_w%0d", WS[i]), wr_ptr[i] > 500, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
